pcle_period_timer: RTL and testbench
====================================

Name: pcle_period_timer

Overview:
Registered sequential stage built around the loadable up-counter next-state slice. It holds the count register, a reload register and a small run-control FSM. It produces a programmable-period tick: the counter runs from the reload value up to all-ones, then emits a one-cycle terminal-count pulse and either reloads or stops. It sits directly downstream of the combinational next-state slice and drives the slice's load, enable and inhibit terms. Its count output is the slice's present-state input.

Parameters:
WIDTH, 8, counter and reload width in bits
RELOAD_RST, 0, reset value of the reload register

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
cfg_wr  in  1  write reload_val into the reload register
reload_val  in  WIDTH  new reload value
load  in  1  direct load of count from load_data; highest priority after reset
load_data  in  WIDTH  direct-load value
start  in  1  arm the timer from IDLE or DONE
stop  in  1  abort a run and return to IDLE
tick  in  1  count enable (slice j term)
inhibit  in  1  count inhibit (slice k term)
auto_reload  in  1  in RUN, reload on terminal count instead of stopping
count  out  WIDTH  registered counter value
tc_pulse  out  1  registered, one cycle after the terminal-count increment
done  out  1  high in DONE
busy  out  1  high in RUN

Behaviour:
- Reset (synchronous, active-high; clock and reset as named above): count=0, reload=RELOAD_RST, state=IDLE, tc_pulse=0, done=0, busy=0. Reset dominates every other input, including mid-run.
- Reload register: written on cfg_wr in any state. It takes effect on the next start or auto-reload, never on the current count.
- advance = tick & ~inhibit & ~load.
- term = advance & (count == all-ones). This matches the slice carry term.
- FSM states are IDLE, RUN and DONE, encoded 2 bits in the package.
- IDLE:
  - count holds.
  - start -> count<=reload, go RUN.
  - stop is ignored.
- RUN:
  - Priority: stop > load > term > advance.
  - stop -> count<=0, go IDLE, no tc_pulse.
  - load -> count<=load_data, stay RUN.
  - term & auto_reload -> count<=reload, tc_pulse<=1, stay RUN.
  - term & ~auto_reload -> count<=0, tc_pulse<=1, go DONE.
  - advance -> count<=count+1, modulo 2^WIDTH.
  - Otherwise count holds.
  - start is ignored in RUN.
- DONE:
  - count holds at 0.
  - start -> count<=reload, go RUN.
  - stop -> go IDLE.
  - start & stop together -> stop wins.
- load in IDLE or DONE: count<=load_data, state unchanged.
- start & load in the same cycle in IDLE or DONE: start wins; count<=reload.
- tc_pulse: high exactly one cycle per terminal count, registered. Back-to-back terminal counts with reload=all-ones and tick held high give tc_pulse high every cycle.
- Period with tick held high and auto_reload=1 is (2^WIDTH - reload) cycles.
- done=(state==DONE), busy=(state==RUN). Both are registered, i.e. decoded from the state register.
- Arithmetic: increment truncated to WIDTH, no carry stored; the carry appears only as tc_pulse.

Decomposition:
- Package pcle_pkg holds:
  - state typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 recovers to IDLE)
  - default WIDTH constant
- One sub-module, pcle_next_state: combinational next-count and term from (count, load, load_data, advance). The FSM and registers stay in the top.

Test Plan:
- Reset mid-run: RUN, count=0x37, assert reset one cycle -> count=0, IDLE, tc_pulse=0, reload=RELOAD_RST.
- One-shot: cfg_wr reload=0xFC, start, tick=1 -> count FC,FD,FE,FF, then tc_pulse=1 for one cycle, count=0, done=1, busy=0.
- Auto-reload: reload=0xFE, auto_reload=1, tick=1 for 6 cycles after start -> tc_pulse every 2 cycles, count alternates FE/FF, state stays RUN.
- Inhibit/gaps: count=0xFF in RUN, inhibit=1 or tick=0 for 3 cycles -> count holds 0xFF, no tc_pulse; release -> tc_pulse next cycle.
- Priorities: in RUN at count=0xFF with tick=1, assert load=1 with load_data=0x10 -> count=0x10, no tc_pulse. Same cycle with stop=1 -> IDLE, count=0.
- Start from DONE with cfg_wr in the same cycle (reload 0x80 -> 0x40) -> count=0x80 (old reload); the next start uses 0x40.

Source files
------------

// File: rtl/pcle_pkg.sv
// Shared types and defaults for the programmable-period timer.
package pcle_pkg;

  localparam int unsigned WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : pcle_pkg

// File: rtl/pcle_next_state.sv
// Loadable up-counter next-state slice: next count and terminal-count carry.
module pcle_next_state #(
  parameter int unsigned WIDTH = pcle_pkg::WIDTH_DEF
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             advance_i,
  output logic [WIDTH-1:0] next_count_c,
  output logic             term_c
);

  always_comb begin
    next_count_c = count_i;
    if (load_i) begin
      next_count_c = load_data_i;
    end else if (advance_i) begin
      next_count_c = count_i + WIDTH'(1);
    end
  end

  assign term_c = advance_i & (&count_i);

endmodule : pcle_next_state

// File: rtl/pcle_period_timer.sv
// Programmable-period tick timer: count/reload registers plus IDLE/RUN/DONE control.
module pcle_period_timer
  import pcle_pkg::*;
#(
  parameter int unsigned     WIDTH      = WIDTH_DEF,
  parameter logic [WIDTH-1:0] RELOAD_RST = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_wr,
  input  logic [WIDTH-1:0] reload_val,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  input  logic             stop,
  input  logic             tick,
  input  logic             inhibit,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc_pulse,
  output logic             done,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             done_q, busy_q;

  logic             advance_c;
  logic [WIDTH-1:0] slice_next_c;
  logic             term_c;

  assign advance_c = tick & ~inhibit & ~load;

  pcle_next_state #(.WIDTH(WIDTH)) u_next_state (
    .count_i      (count_q),
    .load_i       (load),
    .load_data_i  (load_data),
    .advance_i    (advance_c),
    .next_count_c (slice_next_c),
    .term_c       (term_c)
  );

  // New reload value only affects the count at the next start/auto-reload.
  assign reload_d = cfg_wr ? reload_val : reload_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          count_d = reload_q;
          state_d = ST_RUN;
        end else if (load) begin
          count_d = load_data;
        end
      end
      ST_RUN: begin
        if (stop) begin
          count_d = '0;
          state_d = ST_IDLE;
        end else if (load) begin
          count_d = slice_next_c;
        end else if (term_c) begin
          tc_d = 1'b1;
          if (auto_reload) begin
            count_d = reload_q;
          end else begin
            count_d = '0;
            state_d = ST_DONE;
          end
        end else begin
          count_d = slice_next_c;
        end
      end
      ST_DONE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          count_d = reload_q;
          state_d = ST_RUN;
        end else if (load) begin
          count_d = load_data;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= RELOAD_RST;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      done_q   <= (state_d == ST_DONE);
      busy_q   <= (state_d == ST_RUN);
    end
  end

  assign count    = count_q;
  assign tc_pulse = tc_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule : pcle_period_timer

// File: tb/tb_pcle_period_timer.sv
// Directed testbench for pcle_period_timer with hand-computed expectations.
module tb_pcle_period_timer;

  localparam int unsigned WIDTH = 8;

  logic             clock;
  logic             reset;
  logic             cfg_wr;
  logic [WIDTH-1:0] reload_val;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic             start;
  logic             stop;
  logic             tick;
  logic             inhibit;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             tc_pulse;
  logic             done;
  logic             busy;

  int nvec;
  int nerr;

  pcle_period_timer #(.WIDTH(WIDTH), .RELOAD_RST(8'h00)) dut (
    .clock       (clock),
    .reset       (reset),
    .cfg_wr      (cfg_wr),
    .reload_val  (reload_val),
    .load        (load),
    .load_data   (load_data),
    .start       (start),
    .stop        (stop),
    .tick        (tick),
    .inhibit     (inhibit),
    .auto_reload (auto_reload),
    .count       (count),
    .tc_pulse    (tc_pulse),
    .done        (done),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    nvec++;
    if (count !== 8'h00 || tc_pulse !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL reset: count=%h tc=%b done=%b busy=%b, want 00 0 0 0", count, tc_pulse, done, busy);
    end
  endtask

  task automatic test_one_shot();
    cfg_wr = 1'b1; reload_val = 8'hFC;
    step();
    cfg_wr = 1'b0; start = 1'b1;
    step();
    start = 1'b0; tick = 1'b1;
    nvec++;
    if (count !== 8'hFC || busy !== 1'b1) begin
      nerr++;
      $display("FAIL one_shot_start: count=%h busy=%b, want FC 1", count, busy);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      nvec++;
      if (count !== 8'(8'hFC + i) || tc_pulse !== 1'b0) begin
        nerr++;
        $display("FAIL one_shot_count%0d: count=%h tc=%b, want %h 0", i, count, tc_pulse, 8'(8'hFC + i));
      end
    end
    step();
    nvec++;
    if (count !== 8'h00 || tc_pulse !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL one_shot_tc: count=%h tc=%b done=%b busy=%b, want 00 1 1 0", count, tc_pulse, done, busy);
    end
    step();
    nvec++;
    if (count !== 8'h00 || tc_pulse !== 1'b0 || done !== 1'b1) begin
      nerr++;
      $display("FAIL one_shot_hold: count=%h tc=%b done=%b, want 00 0 1", count, tc_pulse, done);
    end
  endtask

  task automatic test_auto_reload();
    cfg_wr = 1'b1; reload_val = 8'hFE;
    step();
    cfg_wr = 1'b0; start = 1'b1; auto_reload = 1'b1; tick = 1'b1;
    step();
    start = 1'b0;
    nvec++;
    if (count !== 8'hFE || busy !== 1'b1 || done !== 1'b0) begin
      nerr++;
      $display("FAIL auto_start: count=%h busy=%b done=%b, want FE 1 0", count, busy, done);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      nvec++;
      if (count !== ((i % 2 == 0) ? 8'hFF : 8'hFE) || tc_pulse !== (i % 2 == 1) || busy !== 1'b1) begin
        nerr++;
        $display("FAIL auto_cycle%0d: count=%h tc=%b busy=%b, want %h %b 1", i, count, tc_pulse, busy,
                 (i % 2 == 0) ? 8'hFF : 8'hFE, (i % 2 == 1));
      end
    end
  endtask

  task automatic test_inhibit_gaps();
    step();
    nvec++;
    if (count !== 8'hFF || tc_pulse !== 1'b0) begin
      nerr++;
      $display("FAIL gap_setup: count=%h tc=%b, want FF 0", count, tc_pulse);
    end
    inhibit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      nvec++;
      if (count !== 8'hFF || tc_pulse !== 1'b0) begin
        nerr++;
        $display("FAIL inhibit_hold%0d: count=%h tc=%b, want FF 0", i, count, tc_pulse);
      end
    end
    inhibit = 1'b0; tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      nvec++;
      if (count !== 8'hFF || tc_pulse !== 1'b0) begin
        nerr++;
        $display("FAIL notick_hold%0d: count=%h tc=%b, want FF 0", i, count, tc_pulse);
      end
    end
    tick = 1'b1;
    step();
    nvec++;
    if (count !== 8'hFE || tc_pulse !== 1'b1 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL gap_release: count=%h tc=%b busy=%b, want FE 1 1", count, tc_pulse, busy);
    end
  endtask

  task automatic test_priorities();
    step();
    load = 1'b1; load_data = 8'h10;
    step();
    nvec++;
    if (count !== 8'h10 || tc_pulse !== 1'b0 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL load_over_term: count=%h tc=%b busy=%b, want 10 0 1", count, tc_pulse, busy);
    end
    load_data = 8'hFF;
    step();
    stop = 1'b1;
    step();
    stop = 1'b0; load = 1'b0;
    nvec++;
    if (count !== 8'h00 || tc_pulse !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      nerr++;
      $display("FAIL stop_over_load: count=%h tc=%b busy=%b done=%b, want 00 0 0 0", count, tc_pulse, busy, done);
    end
    // IDLE: load changes count only, tick is ignored.
    load = 1'b1; load_data = 8'h5A;
    step();
    load = 1'b0;
    step();
    nvec++;
    if (count !== 8'h5A || busy !== 1'b0) begin
      nerr++;
      $display("FAIL idle_load: count=%h busy=%b, want 5A 0", count, busy);
    end
    tick = 1'b0; auto_reload = 1'b0;
  endtask

  task automatic test_start_cfg_same_cycle();
    cfg_wr = 1'b1; reload_val = 8'h80;
    step();
    cfg_wr = 1'b0; start = 1'b1;
    step();
    start = 1'b0; load = 1'b1; load_data = 8'hFF;
    step();
    load = 1'b0; tick = 1'b1;
    step();
    tick = 1'b0;
    nvec++;
    if (done !== 1'b1 || tc_pulse !== 1'b1 || count !== 8'h00) begin
      nerr++;
      $display("FAIL reach_done: done=%b tc=%b count=%h, want 1 1 00", done, tc_pulse, count);
    end
    start = 1'b1; cfg_wr = 1'b1; reload_val = 8'h40;
    step();
    start = 1'b0; cfg_wr = 1'b0;
    nvec++;
    if (count !== 8'h80 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL old_reload: count=%h busy=%b, want 80 1", count, busy);
    end
    stop = 1'b1;
    step();
    stop = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    nvec++;
    if (count !== 8'h40 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL new_reload: count=%h busy=%b, want 40 1", count, busy);
    end
  endtask

  task automatic test_back_to_back();
    stop = 1'b1;
    step();
    stop = 1'b0; cfg_wr = 1'b1; reload_val = 8'hFF;
    step();
    cfg_wr = 1'b0; start = 1'b1; auto_reload = 1'b1; tick = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      nvec++;
      if (count !== 8'hFF || tc_pulse !== 1'b1 || busy !== 1'b1) begin
        nerr++;
        $display("FAIL b2b_tc%0d: count=%h tc=%b busy=%b, want FF 1 1", i, count, tc_pulse, busy);
      end
    end
    tick = 1'b0; auto_reload = 1'b0;
  endtask

  task automatic test_done_start_stop();
    load = 1'b1; load_data = 8'hFF;
    step();
    load = 1'b0; tick = 1'b1;
    step();
    tick = 1'b0;
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    nvec++;
    if (done !== 1'b0 || busy !== 1'b0 || count !== 8'h00) begin
      nerr++;
      $display("FAIL done_stop_wins: done=%b busy=%b count=%h, want 0 0 00", done, busy, count);
    end
  endtask

  task automatic test_reset_mid_run();
    load = 1'b1; load_data = 8'h37; start = 1'b1;
    step();
    start = 1'b0;
    step();
    load = 1'b0;
    nvec++;
    if (count !== 8'h37 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL pre_reset: count=%h busy=%b, want 37 1", count, busy);
    end
    reset = 1'b1; tick = 1'b1;
    step();
    reset = 1'b0; tick = 1'b0;
    nvec++;
    if (count !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || tc_pulse !== 1'b0) begin
      nerr++;
      $display("FAIL mid_run_reset: count=%h busy=%b done=%b tc=%b, want 00 0 0 0", count, busy, done, tc_pulse);
    end
    load = 1'b1; load_data = 8'h99;
    step();
    load = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    nvec++;
    if (count !== 8'h00 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL reload_reset_value: count=%h busy=%b, want 00 1", count, busy);
    end
  endtask

  initial begin
    nvec = 0; nerr = 0;
    reset = 1'b1; cfg_wr = 1'b0; reload_val = '0; load = 1'b0; load_data = '0;
    start = 1'b0; stop = 1'b0; tick = 1'b0; inhibit = 1'b0; auto_reload = 1'b0;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_inhibit_gaps();
    test_priorities();
    test_start_cfg_same_cycle();
    test_back_to_back();
    test_done_start_stop();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule : tb_pcle_period_timer
